// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO with exact full/empty,
// occupancy count, programmable almost-full/almost-empty thresholds and
// sticky overflow/underflow error flags.
//
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through reads
// (rd_data shows the head word combinationally, fifo_rd acknowledges it).
// Without it, reads are registered with one cycle of latency.
module sync_fifo_param #(
  parameter int bw_data   = 24,
  parameter int DEPTH     = 8,
  parameter int ptr_width = 3,
  parameter int AF_LEVEL  = 6,
  parameter int AE_LEVEL  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [bw_data-1:0]   wr_data,
  input  logic                 fifo_wr,
  input  logic                 fifo_rd,
  output logic [bw_data-1:0]   rd_data,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ptr_width:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam logic [ptr_width:0] DEPTH_C = (ptr_width+1)'(DEPTH);
  localparam logic [ptr_width:0] AF_C    = (ptr_width+1)'(AF_LEVEL);
  localparam logic [ptr_width:0] AE_C    = (ptr_width+1)'(AE_LEVEL);

  logic [bw_data-1:0] mem [DEPTH];
  logic [ptr_width:0] wr_ptr;
  logic [ptr_width:0] rd_ptr;
  logic               wr_en;
  logic               rd_en;

  // Requests are qualified by the flags registered at the start of the cycle,
  // so a write on full or a read on empty is simply dropped.
  assign wr_en = fifo_wr & ~full;
  assign rd_en = fifo_rd & ~empty;

  // Flags decode the count register only; pointers never decide full/empty.
  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // Storage write; contents survive reset since nothing can read them until
  // they are rewritten.
  always_ff @(posedge clk) begin
    if (!reset && wr_en)
      mem[wr_ptr[ptr_width-1:0]] <= wr_data;
  end

  // Pointers and occupancy; the low pointer bits index mem, so wrap is free.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags: any dropped request latches until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (fifo_wr && full)  overflow  <= 1'b1;
      if (fifo_rd && empty) underflow <= 1'b1;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is always presented; fifo_rd only advances rd_ptr.
  assign rd_data = mem[rd_ptr[ptr_width-1:0]];
`else
  // Registered read: one-cycle latency, holds value when no read occurs.
  always_ff @(posedge clk) begin
    if (reset)
      rd_data <= '0;
    else if (rd_en)
      rd_data <= mem[rd_ptr[ptr_width-1:0]];
  end
`endif

endmodule
